// File: rtl/sign_mag_divider.sv
// Sequential restoring divider for sign-magnitude operands.
// A DIVIDEND_W-bit dividend is divided by a DIVISOR_W-bit divisor, one quotient
// bit per clock, MSB first. Results are held until the next accepted start.
module sign_mag_divider #(
    parameter int DIVIDEND_W = 5,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic [DIVIDEND_W-1:0] Quotient,
    output logic [DIVISOR_W-1:0]  Remainder,
    output logic                  ZF,
    output logic                  SF,
    output logic                  DZ,
    output logic                  busy,
    output logic                  done
);

    localparam int QM_W  = DIVIDEND_W - 1;
    localparam int RM_W  = DIVISOR_W - 1;
    localparam int CNT_W = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;

    logic [QM_W-1:0]   a_work;
    logic              a_sign;
    logic [RM_W-1:0]   b_mag;
    logic              b_sign;
    logic [QM_W-1:0]   q_mag;
    logic [CNT_W-1:0]  count;

    // The partial remainder stays below |B| between steps, so only its
    // shifted candidate needs the full divisor width (up to 2*|B|-1).
    logic [RM_W-1:0]      rem;
    logic [DIVISOR_W-1:0] shifted;
    logic                 fits;
    logic [RM_W-1:0]      diff;

    // Pack a sign and magnitude, suppressing negative zero.
    function automatic logic [DIVIDEND_W-1:0] pack_q(input logic s, input logic [QM_W-1:0] m);
        return {s && (m != '0), m};
    endfunction

    function automatic logic [DIVISOR_W-1:0] pack_r(input logic s, input logic [RM_W-1:0] m);
        return {s && (m != '0), m};
    endfunction

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign shifted = {rem, a_work[QM_W-1]};
    assign fits    = shifted >= {1'b0, b_mag};
    assign diff    = RM_W'(shifted - {1'b0, b_mag});

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if ((b_mag == '0) || (count == '0)) state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            Quotient  <= '0;
            Remainder <= '0;
            ZF        <= 1'b0;
            SF        <= 1'b0;
            DZ        <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            a_work <= A[QM_W-1:0];
            a_sign <= A[DIVIDEND_W-1];
            b_mag  <= B[RM_W-1:0];
            b_sign <= B[DIVISOR_W-1];
            rem    <= '0;
            q_mag  <= '0;
            count  <= CNT_W'(QM_W);
            ZF     <= 1'b0;
            SF     <= 1'b0;
            DZ     <= 1'b0;
        end else if (state == CALC) begin
            if (b_mag == '0) begin
                Quotient  <= '0;
                Remainder <= '0;
                ZF        <= 1'b1;
                SF        <= 1'b0;
                DZ        <= 1'b1;
                count     <= '0;
            end else if (count != '0) begin
                rem    <= fits ? diff : shifted[RM_W-1:0];
                q_mag  <= {q_mag[QM_W-2:0], fits};
                a_work <= a_work << 1;
                count  <= count - CNT_W'(1);
            end else begin
                Quotient  <= pack_q(a_sign ^ b_sign, q_mag);
                Remainder <= pack_r(a_sign, rem);
                ZF        <= (q_mag == '0);
                SF        <= (a_sign ^ b_sign) && (q_mag != '0);
            end
        end
    end

endmodule

// File: tb/tb_sign_mag_divider.sv
// Scoreboard bench for sign_mag_divider: stimulus pushes expected results
// computed with signed integer division; a monitor pops on every done pulse.
module tb_sign_mag_divider;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] A;
    logic [2:0] B;
    logic [4:0] Quotient;
    logic [2:0] Remainder;
    logic       ZF, SF, DZ, busy, done;

    always #5 clk = ~clk;

    sign_mag_divider #(.DIVIDEND_W(5), .DIVISOR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Quotient(Quotient), .Remainder(Remainder),
        .ZF(ZF), .SF(SF), .DZ(DZ), .busy(busy), .done(done)
    );

    typedef struct {
        logic [4:0] q;
        logic [2:0] r;
        logic       zf, sf, dz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: signed integer division truncating toward zero, remainder
    // takes the dividend's sign; results re-encoded as sign-magnitude.
    function automatic exp_t model(input logic [4:0] a, input logic [2:0] b, input int c);
        exp_t e;
        int av, bv, q, r, qa, ra;
        av = a[4] ? -int'(a[3:0]) : int'(a[3:0]);
        bv = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
        if (bv == 0) begin
            e.q = 5'b0; e.r = 3'b0; e.zf = 1'b1; e.sf = 1'b0; e.dz = 1'b1;
            e.cyc = c + 2;
        end else begin
            q  = av / bv;
            r  = av % bv;
            qa = (q < 0) ? -q : q;
            ra = (r < 0) ? -r : r;
            e.q  = {q < 0, 4'(qa)};
            e.r  = {r < 0, 2'(ra)};
            e.zf = (q == 0);
            e.sf = (q < 0);
            e.dz = 1'b0;
            e.cyc = c + 6;
        end
        return e;
    endfunction

    function automatic logic [4:0] enc5(input int v);
        return {v < 0, 4'((v < 0) ? -v : v)};
    endfunction

    function automatic logic [2:0] enc3(input int v);
        return {v < 0, 2'((v < 0) ? -v : v)};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("quotient",  {27'b0, Quotient},  {27'b0, e.q});
                check("remainder", {29'b0, Remainder}, {29'b0, e.r});
                check("zf",        {31'b0, ZF},        {31'b0, e.zf});
                check("sf",        {31'b0, SF},        {31'b0, e.sf});
                check("dz",        {31'b0, DZ},        {31'b0, e.dz});
                check("latency",   cyc,                e.cyc);
            end
        end
    end

    // Drive one start pulse; must be called right after a falling edge
    task automatic issue(input logic [4:0] a, input logic [2:0] b, input bit push);
        A = a;
        B = b;
        start = 1'b1;
        if (push) sb.push_back(model(a, b, cyc));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Wait for a done pulse, leaving the caller on that falling edge
    task automatic wait_done_pulse();
        int n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected a pulse");
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_quotient"},  {27'b0, Quotient},  32'd0);
        check({tag, "_remainder"}, {29'b0, Remainder}, 32'd0);
        check({tag, "_flags"},     {29'b0, ZF, SF, DZ}, 32'd0);
        check({tag, "_busy_done"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        int p;
        rst = 1'b1; start = 1'b0; A = 5'b0; B = 3'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        // Directed cases, with the result checked again while held in IDLE
        @(negedge clk); issue(5'b01001, 3'b011, 1); wait_empty();
        repeat (2) @(negedge clk);
        check("held_q_9_3", {27'b0, Quotient}, 32'b00011);
        check("held_r_9_3", {29'b0, Remainder}, 32'b000);

        @(negedge clk); issue(5'b11111, 3'b010, 1); wait_empty();
        @(negedge clk);
        check("held_q_m15_2", {27'b0, Quotient}, 32'b10111);
        check("held_r_m15_2", {29'b0, Remainder}, 32'b101);

        @(negedge clk); issue(5'b00010, 3'b111, 1); wait_empty();
        @(negedge clk);
        check("held_q_no_negzero", {27'b0, Quotient}, 32'b00000);
        check("held_r_2_m3", {29'b0, Remainder}, 32'b010);
        check("held_zf_2_m3", {31'b0, ZF}, 32'd1);

        @(negedge clk); issue(5'b00101, 3'b000, 1); wait_empty();
        @(negedge clk);
        check("held_dz_b000", {31'b0, DZ}, 32'd1);
        @(negedge clk); issue(5'b00101, 3'b100, 1); wait_empty();
        @(negedge clk);
        check("held_dz_b100", {31'b0, DZ}, 32'd1);

        // A start during CALC is ignored; only the first operation reports
        @(negedge clk); issue(5'b01001, 3'b011, 1);
        @(negedge clk); issue(5'b00111, 3'b001, 0);
        wait_empty();
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation abandons it
        @(negedge clk); issue(5'b01001, 3'b011, 0);
        @(negedge clk); issue(5'b00101, 3'b001, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_cleared("mid_reset");
        repeat (8) @(negedge clk);
        issue(5'b01010, 3'b010, 1); wait_empty();

        // Product/factor sweep, chained back-to-back in each DONE cycle
        @(negedge clk);
        issue(5'b00000, 3'b001, 1);
        for (int a = -3; a <= 3; a++) begin
            for (int b = -3; b <= 3; b++) begin
                if (b != 0) begin
                    p = a * b;
                    wait_done_pulse();
                    issue(enc5(p), enc3(b), 1);
                end
            end
        end
        wait_empty();

        // Random operands, randomly back-to-back or with idle gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                wait_done_pulse();
            end else begin
                wait_empty();
                repeat ($urandom_range(2, 0)) @(negedge clk);
                @(negedge clk);
            end
            issue(5'($urandom), 3'($urandom), 1);
        end
        wait_empty();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
